// File: rtl/uart_tx_arbiter_if.sv
// Producer/arbiter bundle for uart_tx_arbiter: requests and bytes in, grants and uart_tx drive out.
// Handshake: i_req[k] is a level "valid" held with i_data byte k; o_gnt[k] is the one-cycle "ready/accept" pulse.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   i_req;
  logic [8*NUM_REQ-1:0] i_data;
  logic [NUM_REQ-1:0]   o_gnt;
  logic [7:0]           o_tx_data;
  logic                 o_tx_send;
  logic                 o_busy;
  logic [ID_W-1:0]      o_last_id;
  logic [1:0]           o_state;

  modport master (
    output i_req, i_data,
    input  o_gnt, o_tx_data, o_tx_send, o_busy, o_last_id, o_state
  );

  modport slave (
    input  i_req, i_data,
    output o_gnt, o_tx_data, o_tx_send, o_busy, o_last_id, o_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers, with internal frame pacing.
// Optional: define UART_ARB_PRIO0_EN to give requester 0 fixed highest priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 310_000,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int TW = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [7:0]          r_tx_data;
  logic                r_tx_send;
  logic                r_busy;
  logic [ID_W-1:0]     r_last_id;
  logic [ID_W-1:0]     r_ptr;
  logic [TW-1:0]       r_timer;

  logic                w_any;
  logic [ID_W-1:0]     w_win;
  logic [ID_W-1:0]     w_idx;
  logic [ID_W:0]       w_sum;
  logic [ID_W-1:0]     w_next_ptr;

  // Scan pointer, pointer+1, ... with wrap; the first set request wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    w_sum = '0;
`ifdef UART_ARB_PRIO0_EN
    if (bus.i_req[0]) w_any = 1'b1;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(i);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_any && bus.i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_next_ptr = (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + ID_W'(1);
`ifdef UART_ARB_PRIO0_EN
    // A priority grant to requester 0 leaves the rotation untouched.
    if (w_win == '0) w_next_ptr = r_ptr;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_tx_data <= 8'h00;
      r_tx_send <= 1'b0;
      r_busy    <= 1'b0;
      r_last_id <= '0;
      r_ptr     <= '0;
      r_timer   <= '0;
    end else begin
      r_gnt     <= '0;
      r_tx_send <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt     <= NUM_REQ'(1) << w_win;
            r_tx_data <= bus.i_data[{w_win, 3'b000} +: 8];
            r_last_id <= w_win;
            r_ptr     <= w_next_ptr;
            r_busy    <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_tx_send <= 1'b1;
          r_state   <= SEND;
        end
        SEND: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // uart_tx has no done flag, so the frame plus its post-frame delay is timed here.
          if (r_timer == TW'(FRAME_CYCLES-1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_gnt     = r_gnt;
  assign bus.o_tx_data = r_tx_data;
  assign bus.o_tx_send = r_tx_send;
  assign bus.o_busy    = r_busy;
  assign bus.o_last_id = r_last_id;
  assign bus.o_state   = r_state;
endmodule
